fwd_interlock_unit: RTL and testbench

Parametrised operand-forwarding and load-use interlock unit for the 5-stage pipeline (ID/EX/MEM/WB). It holds its own scoreboard of in-flight destination registers and selects the newest value for both source operands, A and B. It raises a one-cycle stall on load-use hazards and counts stall cycles. It sits between the register-file read ports and the EX-stage operand latches.

---
 rtl/fwd_interlock_unit.sv | 121 ++++++++++++
 tb/tb_fwd_interlock_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_interlock_unit.sv
// Operand-forwarding and load-use interlock for the ID/EX/MEM/WB pipeline.
// Keeps its own EX/MEM/WB destination scoreboard and picks the youngest producer per operand.
module fwd_interlock_unit #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             in_CLK,
  input  logic             in_RST,
  input  logic             in_ID_VALID,
  input  logic [AW-1:0]    in_ID_RS,
  input  logic [AW-1:0]    in_ID_RT,
  input  logic             in_ID_USEA,
  input  logic             in_ID_USEB,
  input  logic [AW-1:0]    in_ID_RD,
  input  logic             in_ID_WE,
  input  logic             in_ID_LOAD,
  input  logic             in_FLUSH,
  input  logic [WIDTH-1:0] in_RFA,
  input  logic [WIDTH-1:0] in_RFB,
  input  logic [WIDTH-1:0] in_EX_R,
  input  logic [WIDTH-1:0] in_MEM_R,
  input  logic [WIDTH-1:0] in_WB,
  output logic [WIDTH-1:0] out_A,
  output logic [WIDTH-1:0] out_B,
  output logic [1:0]       out_CSW_A,
  output logic [1:0]       out_CSW_B,
  output logic             out_STALL,
  output logic [CNT_W-1:0] out_STALL_CNT
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          we;
    logic          load;
  } tag_t;

  tag_t             ex_q, mem_q, wb_q;
  tag_t             ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [AW-1:0]    src     [2];
  logic             use_src [2];
  logic [WIDTH-1:0] rf_val  [2];
  logic [WIDTH-1:0] fwd_val [2];
  logic [1:0]       fwd_sel [2];
  logic [1:0]       stall_req;

  function automatic logic tag_match(input tag_t t, input logic [AW-1:0] s);
    return t.valid && t.we && (t.rd == s) && (s != '0);
  endfunction

  assign src[0]     = in_ID_RS;
  assign src[1]     = in_ID_RT;
  assign use_src[0] = in_ID_USEA;
  assign use_src[1] = in_ID_USEB;
  assign rf_val[0]  = in_RFA;
  assign rf_val[1]  = in_RFB;

  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    logic ex_hit, mem_hit, wb_hit;

    assign ex_hit  = tag_match(ex_q,  src[gi]);
    assign mem_hit = tag_match(mem_q, src[gi]);
    assign wb_hit  = tag_match(wb_q,  src[gi]);

    // A load in EX still claims the operand: its stall covers the invalid value,
    // and an older stage must never win over a younger in-flight writer.
    always_comb begin
      fwd_sel[gi] = 2'b00;
      fwd_val[gi] = rf_val[gi];
      if (ex_hit) begin
        fwd_sel[gi] = 2'b01;
        fwd_val[gi] = in_EX_R;
      end else if (mem_hit) begin
        fwd_sel[gi] = 2'b10;
        fwd_val[gi] = in_MEM_R;
      end else if (wb_hit) begin
        fwd_sel[gi] = 2'b11;
        fwd_val[gi] = in_WB;
      end
    end

    assign stall_req[gi] = use_src[gi] && ex_hit && ex_q.load;
  end

  assign out_A         = fwd_val[0];
  assign out_B         = fwd_val[1];
  assign out_CSW_A     = fwd_sel[0];
  assign out_CSW_B     = fwd_sel[1];
  assign out_STALL     = !in_RST && in_ID_VALID && !in_FLUSH && (|stall_req);
  assign out_STALL_CNT = cnt_q;

  always_comb begin
    ex_d = '0;
    if (in_ID_VALID && !out_STALL && !in_FLUSH) begin
      ex_d.valid = 1'b1;
      ex_d.rd    = in_ID_RD;
      ex_d.we    = in_ID_WE;
      ex_d.load  = in_ID_LOAD;
    end
    cnt_d = cnt_q;
    if (out_STALL && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_interlock_unit.sv
// Self-checking bench for fwd_interlock_unit: directed hazard scenarios plus random
// instruction streams, all compared against a stage-list model of the pipeline.
module tb_fwd_interlock_unit;

  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_usea, id_useb, id_we, id_load, flush;
  logic [AW-1:0]    id_rs, id_rt, id_rd;
  logic [WIDTH-1:0] rfa, rfb, ex_r, mem_r, wb_r;
  logic [WIDTH-1:0] out_a, out_b;
  logic [1:0]       csw_a, csw_b;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  fwd_interlock_unit #(.WIDTH(WIDTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .in_CLK(clk), .in_RST(rst), .in_ID_VALID(id_valid),
    .in_ID_RS(id_rs), .in_ID_RT(id_rt), .in_ID_USEA(id_usea), .in_ID_USEB(id_useb),
    .in_ID_RD(id_rd), .in_ID_WE(id_we), .in_ID_LOAD(id_load), .in_FLUSH(flush),
    .in_RFA(rfa), .in_RFB(rfb), .in_EX_R(ex_r), .in_MEM_R(mem_r), .in_WB(wb_r),
    .out_A(out_a), .out_B(out_b), .out_CSW_A(csw_a), .out_CSW_B(csw_b),
    .out_STALL(stall), .out_STALL_CNT(stall_cnt)
  );

  // Model: in-flight writers listed youngest first (index 0 = EX, 1 = MEM, 2 = WB).
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } rec_t;

  rec_t        pipe [3];
  int unsigned m_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [WIDTH-1:0] obs_a, obs_b;
  logic [1:0]       obs_csw_a, obs_csw_b;
  logic             obs_stall;
  logic [CNT_W-1:0] obs_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit writes(input rec_t r, input int s);
    return r.v && r.we && (r.rd == s) && (s != 0);
  endfunction

  // Youngest in-flight writer of s wins; nobody in flight means the RF value.
  task automatic model_fwd(input int s, input logic [WIDTH-1:0] rf,
                           output logic [WIDTH-1:0] val, output logic [1:0] sel);
    logic [WIDTH-1:0] res [3];
    res[0] = ex_r; res[1] = mem_r; res[2] = wb_r;
    val = rf;
    sel = 2'b00;
    for (int k = 2; k >= 0; k--) begin
      if (writes(pipe[k], s)) begin
        val = res[k];
        sel = 2'(k + 1);
      end
    end
  endtask

  task automatic step(input bit v, input int rs, input int rt, input bit ua, input bit ub,
                      input int rd, input bit we, input bit ld, input bit fl, input bit rs_t);
    logic [WIDTH-1:0] ea, eb;
    logic [1:0]       sa, sb;
    bit               es;
    rec_t             nr;
    @(negedge clk);
    rst = rs_t; id_valid = v; id_rs = AW'(rs); id_rt = AW'(rt);
    id_usea = ua; id_useb = ub; id_rd = AW'(rd); id_we = we; id_load = ld; flush = fl;
    rfa = $urandom; rfb = $urandom; ex_r = $urandom; mem_r = $urandom; wb_r = $urandom;
    #1;
    model_fwd(rs, rfa, ea, sa);
    model_fwd(rt, rfb, eb, sb);
    es = !rs_t && v && !fl && pipe[0].ld &&
         ((ua && writes(pipe[0], rs)) || (ub && writes(pipe[0], rt)));
    obs_a = out_a; obs_b = out_b; obs_csw_a = csw_a; obs_csw_b = csw_b;
    obs_stall = stall; obs_cnt = stall_cnt;
    check("csw_a", 64'(csw_a), 64'(sa));
    check("csw_b", 64'(csw_b), 64'(sb));
    if (!es) begin
      check("out_a", 64'(out_a), 64'(ea));
      check("out_b", 64'(out_b), 64'(eb));
    end
    check("stall", 64'(stall), 64'(es));
    check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    @(posedge clk);
    if (rs_t) begin
      foreach (pipe[k]) pipe[k] = '{0, 0, 0, 0};
      m_cnt = 0;
    end else begin
      nr = '{0, 0, 0, 0};
      if (v && !es && !fl) nr = '{1, rd, we, ld};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nr;
      if (es && m_cnt < CMAX) m_cnt++;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    foreach (pipe[k]) pipe[k] = '{0, 0, 0, 0};
    m_cnt = 0;
    rst = 1'b1; id_valid = 0; id_rs = '0; id_rt = '0; id_usea = 0; id_useb = 0;
    id_rd = '0; id_we = 0; id_load = 0; flush = 0;
    rfa = '0; rfb = '0; ex_r = '0; mem_r = '0; wb_r = '0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 3, 4, 1, 1, 0, 0, 0, 0, 0);
    check("rst_csw_a", 64'(obs_csw_a), 64'(2'b00));
    check("rst_a_rf", 64'(obs_a), 64'(rfa));
    check("rst_cnt", 64'(obs_cnt), 64'(0));

    // ALU result forwarded from EX.
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    step(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    check("alu_csw_a", 64'(obs_csw_a), 64'(2'b01));
    check("alu_a_ex", 64'(obs_a), 64'(ex_r));
    check("alu_nostall", 64'(obs_stall), 64'(0));

    // Load-use: one stall, then the load value comes from MEM.
    step(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    step(1, 0, 5, 0, 1, 0, 0, 0, 0, 0);
    check("lu_stall", 64'(obs_stall), 64'(1));
    step(1, 0, 5, 0, 1, 0, 0, 0, 0, 0);
    check("lu_stall_once", 64'(obs_stall), 64'(0));
    check("lu_csw_b", 64'(obs_csw_b), 64'(2'b10));
    check("lu_b_mem", 64'(obs_b), 64'(mem_r));
    check("lu_cnt", 64'(obs_cnt), 64'(1));

    // Youngest writer of r7 wins as older copies drain.
    repeat (3) step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    step(1, 7, 0, 1, 0, 0, 0, 0, 0, 0);
    check("prio_ex", 64'(obs_csw_a), 64'(2'b01));
    step(1, 7, 0, 1, 0, 0, 0, 0, 0, 0);
    check("prio_mem", 64'(obs_csw_a), 64'(2'b10));
    step(1, 7, 0, 1, 0, 0, 0, 0, 0, 0);
    check("prio_wb", 64'(obs_csw_a), 64'(2'b11));
    check("prio_wb_val", 64'(obs_a), 64'(wb_r));

    // r0 writers are invisible; an unused operand never stalls.
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    check("r0_csw_a", 64'(obs_csw_a), 64'(2'b00));
    step(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
    step(1, 0, 4, 0, 0, 0, 0, 0, 0, 0);
    check("nouse_nostall", 64'(obs_stall), 64'(0));
    check("nouse_csw_b", 64'(obs_csw_b), 64'(2'b01));
    check("nouse_b_ex", 64'(obs_b), 64'(ex_r));

    // Flush beats the stall and leaves a bubble in EX.
    step(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    step(1, 2, 0, 1, 0, 0, 0, 0, 1, 0);
    check("fl_nostall", 64'(obs_stall), 64'(0));
    step(1, 2, 0, 1, 0, 0, 0, 0, 0, 0);
    check("fl_csw_a", 64'(obs_csw_a), 64'(2'b10));
    check("fl_cnt", 64'(obs_cnt), 64'(1));

    // Saturation, then reset in the middle of a stall.
    repeat (5) begin
      step(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    end
    check("sat_cnt", 64'(obs_cnt), 64'(CMAX));
    step(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    check("rst_stall_drop", 64'(obs_stall), 64'(0));
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    check("rst_cnt_clr", 64'(obs_cnt), 64'(0));
    check("rst_tags_clr", 64'(obs_csw_a), 64'(2'b00));

    // Random instruction streams over a small register window to force hazards.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 149) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
